// File: rtl/doodle_physics.sv
// doodle_physics: per-frame motion engine for the Doodle Jump character.
// Owns X/Y position, signed vertical velocity and the play state.
// Gravity, horizontal wrap, platform bounce and floor death are handled here.
// Optional camera scroll is enabled by defining the macro DOODLE_SCROLL_EN.
// When it is defined, the SCROLL_LINE parameter and the scroll_amt/scroll_valid
// ports exist, and the top-of-screen clamp is replaced by the scroll.
module doodle_physics #(
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_START     = 320,
  parameter int Y_START     = 240,
  parameter int SIZE        = 12,
  parameter int JUMP_VEL    = 10,
  parameter int GRAVITY     = 1,
  parameter int GRAV_DIV    = 1,
  parameter int MAX_FALL    = 8,
  parameter int X_SPEED     = 2,
  parameter int VEL_W       = 8
`ifdef DOODLE_SCROLL_EN
  ,
  parameter int SCROLL_LINE = 160
`endif
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic [7:0]              keycode,
  input  logic                    land_hit,
  output logic [9:0]              char_x,
  output logic [9:0]              char_y,
  output logic [9:0]              char_s,
  output logic signed [VEL_W-1:0] vel_y,
  output logic [1:0]              state,
  output logic                    jump_pulse,
  output logic                    dead
`ifdef DOODLE_SCROLL_EN
  ,
  output logic [9:0]              scroll_amt,
  output logic                    scroll_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic signed [10:0]      X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0]      SIZE_S     = 11'(SIZE);
  localparam logic signed [10:0]      FLOOR_S    = 11'(Y_MAX - SIZE);
  localparam logic signed [10:0]      X_SPD_S    = 11'(X_SPEED);
  localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W:0]   MAX_FALL_W = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [VEL_W:0]   GRAV_W     = (VEL_W+1)'(GRAVITY);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(GRAV_DIV - 1);
`ifdef DOODLE_SCROLL_EN
  localparam logic signed [10:0]      SCROLL_S   = 11'(SCROLL_LINE);
`endif

  state_t                  state_q, state_d;
  logic [9:0]              x_q, x_d;
  logic [9:0]              y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    jump_q, jump_d;
`ifdef DOODLE_SCROLL_EN
  logic [9:0]              scroll_amt_q, scroll_amt_d;
  logic                    scroll_valid_q, scroll_valid_d;
  logic signed [10:0]      scroll_diff;
`endif

  logic                    grav_tick;
  logic [CNT_W-1:0]        cnt_next;
  logic signed [VEL_W:0]   vel_sum;
  logic signed [VEL_W-1:0] vel_new;
  logic signed [10:0]      y_next;
  logic signed [10:0]      dx;
  logic signed [10:0]      x_next;
  logic [9:0]              x_wrap;
  logic                    key_right;
  logic                    key_left;

  // Motion candidates for an airborne frame: gravity tick, new velocity, new Y and wrapped X
  always_comb begin
    grav_tick = (cnt_q == CNT_LAST);
    cnt_next  = grav_tick ? '0 : cnt_q + CNT_W'(1);
    vel_sum   = (VEL_W+1)'(vel_q) + GRAV_W;
    if (!grav_tick) begin
      vel_new = vel_q;
    end else if (vel_sum > MAX_FALL_W) begin
      vel_new = MAX_FALL_W[VEL_W-1:0];
    end else begin
      vel_new = vel_sum[VEL_W-1:0];
    end
    y_next    = $signed({1'b0, y_q}) + 11'(vel_new);
    key_right = (keycode == 8'd7) || (keycode == 8'd79);
    key_left  = (keycode == 8'd4) || (keycode == 8'd80);
    if (key_right) begin
      dx = X_SPD_S;
    end else if (key_left) begin
      dx = -X_SPD_S;
    end else begin
      dx = '0;
    end
    x_next = $signed({1'b0, x_q}) + dx;
    if (x_next < 11'sd0) begin
      x_wrap = X_MAX_S[9:0];
    end else if (x_next > X_MAX_S) begin
      x_wrap = '0;
    end else begin
      x_wrap = x_next[9:0];
    end
  end

  // Next-state logic: play-state transitions, bounce, floor death and top handling
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    jump_d  = 1'b0;
`ifdef DOODLE_SCROLL_EN
    scroll_amt_d   = '0;
    scroll_valid_d = 1'b0;
    scroll_diff    = SCROLL_S - y_next;
`endif
    if (!pause) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RISE;
            vel_d   = JUMP_V;
            jump_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        RISE, FALL: begin
          x_d   = x_wrap;
          cnt_d = cnt_next;
          vel_d = vel_new;
          y_d   = y_next[9:0];
          if ((state_q == FALL) && land_hit) begin
            y_d     = y_q;
            vel_d   = JUMP_V;
            state_d = RISE;
            jump_d  = 1'b1;
            cnt_d   = '0;
          end else if ((state_q == FALL) && (y_next >= FLOOR_S)) begin
            y_d     = FLOOR_S[9:0];
            vel_d   = '0;
            state_d = DEAD;
`ifdef DOODLE_SCROLL_EN
          end else if ((state_q == RISE) && (y_next < SCROLL_S)) begin
            y_d            = SCROLL_S[9:0];
            scroll_amt_d   = scroll_diff[9:0];
            scroll_valid_d = 1'b1;
            if (!vel_new[VEL_W-1]) begin
              state_d = FALL;
            end
`else
          end else if (y_next < SIZE_S) begin
            y_d     = SIZE_S[9:0];
            vel_d   = '0;
            state_d = FALL;
`endif
          end else if ((state_q == RISE) && !vel_new[VEL_W-1]) begin
            state_d = FALL;
          end
        end
        DEAD: begin
          if (start) begin
            x_d     = 10'(X_START);
            y_d     = 10'(Y_START);
            vel_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // Frame-rate state registers with asynchronous return to the start position
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= 10'(X_START);
      y_q     <= 10'(Y_START);
      vel_q   <= '0;
      cnt_q   <= '0;
      jump_q  <= 1'b0;
`ifdef DOODLE_SCROLL_EN
      scroll_amt_q   <= '0;
      scroll_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      cnt_q   <= cnt_d;
      jump_q  <= jump_d;
`ifdef DOODLE_SCROLL_EN
      scroll_amt_q   <= scroll_amt_d;
      scroll_valid_q <= scroll_valid_d;
`endif
    end
  end

  assign char_x     = x_q;
  assign char_y     = y_q;
  assign char_s     = 10'(SIZE);
  assign vel_y      = vel_q;
  assign state      = state_q;
  assign jump_pulse = jump_q;
  assign dead       = (state_q == DEAD);
`ifdef DOODLE_SCROLL_EN
  assign scroll_amt   = scroll_amt_q;
  assign scroll_valid = scroll_valid_q;
`endif

endmodule

// File: doc/doodle_physics.md
Name: doodle_physics

Overview:
- Parametrised per-frame motion engine for the Doodle Jump character.
- Owns X/Y position and signed vertical velocity, with gravity, horizontal screen wrap, platform bounce, death at the floor, pause, and an optional camera-scroll output.
- Sits between keyboard decode / platform collision logic and the sprite renderer.
- Successor to the fixed-constant jump logic: screen size, sprite size, jump impulse, gravity rate and speed are all configurable.

Parameters:
- X_MAX, 639, rightmost legal X.
- Y_MAX, 479, bottom (floor) Y.
- X_START, 320, X after reset and after restart.
- Y_START, 240, Y after reset and after restart.
- SIZE, 12, sprite half-size; drives char_s.
- JUMP_VEL, 10, magnitude of upward velocity applied on a jump.
- GRAVITY, 1, added to vel_y on each gravity tick.
- GRAV_DIV, 1, frames per gravity tick (1 = every frame).
- MAX_FALL, 8, clamp on positive (downward) vel_y.
- X_SPEED, 2, horizontal step per frame.
- VEL_W, 8, width of the signed velocity.
- SCROLL_LINE, 160, Y threshold for camera scroll (SCROLL_EN only).

Ports:
- frame_clk  in  1  frame clock; one update per rising edge.
- Reset  in  1  asynchronous, active-high.
- start  in  1  begin play from IDLE; restart from DEAD.
- pause  in  1  freeze all state while high.
- keycode  in  8  USB keycode; 7 or 79 = right, 4 or 80 = left.
- land_hit  in  1  sprite feet overlap a platform this frame.
- char_x  out  10  current X.
- char_y  out  10  current Y.
- char_s  out  10  constant SIZE.
- vel_y  out  VEL_W  signed vertical velocity; negative = up.
- state  out  2  0=IDLE, 1=RISE, 2=FALL, 3=DEAD.
- jump_pulse  out  1  high for one frame on any jump.
- dead  out  1  equals (state==DEAD).

Behaviour:
- Reset is asynchronous, active-high. Clock is frame_clk.
- Reset values: char_x=X_START, char_y=Y_START, vel_y=0, state=IDLE, jump_pulse=0, gravity counter=0.
- All outputs are registered and updated on posedge frame_clk.
- pause=1: no register changes, including the gravity counter; jump_pulse=0.
- IDLE: position held. start=1 -> state RISE, vel_y=-JUMP_VEL, jump_pulse=1, Y unchanged this frame, gravity counter cleared.
- RISE/FALL per-frame order:
  1. Gravity counter increments, wrapping at GRAV_DIV. On wrap to 0, vel_y += GRAVITY, saturating at +MAX_FALL.
  2. y_next = char_y + vel_y (new value), computed with 11-bit signed intermediate.
  3. X steps by +X_SPEED (right key), -X_SPEED (left key), or 0 (any other keycode).
- Horizontal wrap: x_next computed 11-bit signed. x_next < 0 -> char_x=X_MAX. x_next > X_MAX -> char_x=0.
- RISE -> FALL when the updated vel_y >= 0. land_hit is ignored in RISE (pass-through platforms).
- Top clamp (SCROLL_EN absent): y_next < SIZE -> char_y=SIZE, vel_y=0, state FALL.
- FALL with land_hit=1: vel_y=-JUMP_VEL, state RISE, jump_pulse=1, char_y unchanged, gravity counter cleared.
- FALL with land_hit=0 and y_next >= Y_MAX-SIZE: char_y=Y_MAX-SIZE, vel_y=0, state DEAD.
- land_hit and floor contact in the same frame: land_hit wins.
- start is ignored in RISE and FALL.
- DEAD: everything held. start=1 -> restore X_START/Y_START, vel_y=0, state IDLE.
- Reset mid-jump returns immediately to the reset values; no residual velocity.
- jump_pulse is 0 in every frame that is not a jump frame.

Optional Feature:
- Macro: DOODLE_SCROLL_EN.
- When defined, adds two outputs:
  - scroll_amt  out  10  camera scroll this frame.
  - scroll_valid  out  1  high when scroll_amt applies.
- RISE with y_next < SCROLL_LINE: char_y=SCROLL_LINE, scroll_amt=SCROLL_LINE-y_next, scroll_valid=1, vel_y keeps decaying normally. Top clamp is not applied.
- All other frames: scroll_amt=0, scroll_valid=0.
- When undefined: ports absent, top clamp as described in Behaviour.

Test Plan:
- Reset, then start=1 for one frame (defaults): state=1, vel_y=-10, jump_pulse=1, char_y=240. After 10 more frames: vel_y=0, char_y=195, state=2.
- char_x=638, keycode=7 for one RISE frame -> char_x=0. Then char_x=1, keycode=80 -> char_x=639. keycode=0 -> X unchanged.
- In FALL at char_y=300, land_hit=1 -> vel_y=-10, state=1, jump_pulse=1, char_y=300. land_hit=1 during RISE -> no effect.
- Free fall from the apex: vel_y saturates at 8; reaching y_next>=467 -> char_y=467, state=3, dead=1. start=1 -> char_x=320, char_y=240, state=0.
- pause=1 for 5 frames mid-RISE -> char_x, char_y, vel_y, state unchanged; Reset asserted mid-FALL -> reset values asynchronously.
- DOODLE_SCROLL_EN, Y_START=180, start: char_y 171, 163, then 160 with scroll_amt=4, then 160 with scroll_amt=6 (vel_y -7, -6).
